// File: rtl/decode_pkg.sv
// Shared decode definitions: RV base opcodes, ALU/result-source encodings,
// immediate formats and the registered control bundle.
package decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_PASS_B = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_read;
      logic        branch;
      logic        jump;
      logic        muldiv;
      logic        illegal;
      logic        alu_src_a;
      logic        alu_src_b;
      alu_op_e     alu_op;
      result_src_e result_src;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle. slave = decode stage view,
// master = the surrounding pipeline (or bench) view.
interface decode_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instruction;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_imm;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic [2:0]       out_funct3;
   logic [6:0]       out_funct7;
   logic             out_reg_write;
   logic             out_mem_write;
   logic             out_mem_read;
   logic             out_branch;
   logic             out_jump;
   logic             out_muldiv;
   logic             out_illegal;
   logic             out_alu_src_a;
   logic             out_alu_src_b;
   logic [1:0]       out_alu_op;
   logic [1:0]       out_result_src;
   logic [CNT_W-1:0] out_illegal_count;

   modport slave (
      input  in_valid, in_instruction, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_funct3, out_funct7, out_reg_write, out_mem_write, out_mem_read,
             out_branch, out_jump, out_muldiv, out_illegal, out_alu_src_a,
             out_alu_src_b, out_alu_op, out_result_src, out_illegal_count
   );

   modport master (
      output in_valid, in_instruction, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_funct3, out_funct7, out_reg_write, out_mem_write, out_mem_read,
             out_branch, out_jump, out_muldiv, out_illegal, out_alu_src_a,
             out_alu_src_b, out_alu_op, out_result_src, out_illegal_count
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate builder. Takes instruction bits [31:7]
// (the opcode is not needed here) and the format chosen by the decoder.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;

   // Assemble the 32-bit immediate per format, then sign-extend to XLEN.
   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U: imm32 = {instr[31:12], 12'b0};
         FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm = XLEN'(imm32);
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 instruction decode with valid/ready
// flow control, flush and a saturating illegal-instruction counter.
// Optional feature macro: DECODE_RV32M_EN (accept MUL/DIV R-type encodings).
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);

   logic [6:0]       opcode;
   logic [6:0]       funct7;
   ctrl_t            ctrl_p0;
   imm_fmt_e         fmt_p0;
   logic [XLEN-1:0]  imm_p0;
   logic             accept;

   ctrl_t            ctrl_p1;
   logic [XLEN-1:0]  pc_p1;
   logic [XLEN-1:0]  imm_p1;
   logic [31:7]      instr_p1;
   logic             vld_p1;
   logic [CNT_W-1:0] cnt_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign opcode = bus.in_instruction[6:0];
   assign funct7 = bus.in_instruction[31:25];

   // Opcode -> control bundle and immediate format.
   always_comb begin
      ctrl_p0 = '0;
      fmt_p0  = FMT_NONE;
      case (opcode)
         OPC_OP: begin
            ctrl_p0.reg_write = 1'b1;
            ctrl_p0.alu_op    = ALU_FUNCT;
            if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
               ctrl_p0.muldiv  = 1'b1;
`else
               ctrl_p0         = '0;
               ctrl_p0.illegal = 1'b1;
`endif
            end
         end
         OPC_OP_IMM: begin
            ctrl_p0.reg_write = 1'b1;
            ctrl_p0.alu_src_b = 1'b1;
            ctrl_p0.alu_op    = ALU_FUNCT;
            fmt_p0            = FMT_I;
         end
         OPC_LOAD: begin
            ctrl_p0.reg_write  = 1'b1;
            ctrl_p0.mem_read   = 1'b1;
            ctrl_p0.alu_src_b  = 1'b1;
            ctrl_p0.result_src = RES_MEM;
            fmt_p0             = FMT_I;
         end
         OPC_STORE: begin
            ctrl_p0.mem_write = 1'b1;
            ctrl_p0.alu_src_b = 1'b1;
            fmt_p0            = FMT_S;
         end
         OPC_BRANCH: begin
            ctrl_p0.branch = 1'b1;
            ctrl_p0.alu_op = ALU_BRANCH;
            fmt_p0         = FMT_B;
         end
         OPC_JAL: begin
            ctrl_p0.reg_write  = 1'b1;
            ctrl_p0.jump       = 1'b1;
            ctrl_p0.alu_src_a  = 1'b1;
            ctrl_p0.alu_src_b  = 1'b1;
            ctrl_p0.result_src = RES_PC4;
            fmt_p0             = FMT_J;
         end
         OPC_JALR: begin
            ctrl_p0.reg_write  = 1'b1;
            ctrl_p0.jump       = 1'b1;
            ctrl_p0.alu_src_b  = 1'b1;
            ctrl_p0.result_src = RES_PC4;
            fmt_p0             = FMT_I;
         end
         OPC_LUI: begin
            ctrl_p0.reg_write = 1'b1;
            ctrl_p0.alu_src_b = 1'b1;
            ctrl_p0.alu_op    = ALU_PASS_B;
            fmt_p0            = FMT_U;
         end
         OPC_AUIPC: begin
            ctrl_p0.reg_write = 1'b1;
            ctrl_p0.alu_src_a = 1'b1;
            ctrl_p0.alu_src_b = 1'b1;
            fmt_p0            = FMT_U;
         end
         OPC_SYSTEM: ctrl_p0 = '0;
         default:    ctrl_p0.illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded; drop them here.
      if (bus.in_instruction[11:7] == 5'd0) ctrl_p0.reg_write = 1'b0;
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (bus.in_instruction[31:7]),
      .fmt   (fmt_p0),
      .imm   (imm_p0)
   );

   assign bus.in_ready = !vld_p1 || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   // p0 -> p1 output register; flush wins over accept, data held on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         ctrl_p1  <= '0;
         pc_p1    <= '0;
         imm_p1   <= '0;
         instr_p1 <= '0;
         cnt_p1   <= '0;
      end else begin
         if (bus.flush)         vld_p1 <= 1'b0;
         else if (bus.in_ready) vld_p1 <= bus.in_valid;
         if (accept) begin
            ctrl_p1  <= ctrl_p0;
            pc_p1    <= bus.in_pc;
            imm_p1   <= imm_p0;
            instr_p1 <= bus.in_instruction[31:7];
            if (ctrl_p0.illegal) cnt_p1 <= sat_inc(cnt_p1);
         end
      end
   end

   assign bus.out_valid         = vld_p1;
   assign bus.out_pc            = pc_p1;
   assign bus.out_imm           = imm_p1;
   assign bus.out_rs1           = instr_p1[19:15];
   assign bus.out_rs2           = instr_p1[24:20];
   assign bus.out_rd            = instr_p1[11:7];
   assign bus.out_funct3        = instr_p1[14:12];
   assign bus.out_funct7        = instr_p1[31:25];
   assign bus.out_reg_write     = ctrl_p1.reg_write;
   assign bus.out_mem_write     = ctrl_p1.mem_write;
   assign bus.out_mem_read      = ctrl_p1.mem_read;
   assign bus.out_branch        = ctrl_p1.branch;
   assign bus.out_jump          = ctrl_p1.jump;
   assign bus.out_muldiv        = ctrl_p1.muldiv;
   assign bus.out_illegal       = ctrl_p1.illegal;
   assign bus.out_alu_src_a     = ctrl_p1.alu_src_a;
   assign bus.out_alu_src_b     = ctrl_p1.alu_src_b;
   assign bus.out_alu_op        = ctrl_p1.alu_op;
   assign bus.out_result_src    = ctrl_p1.result_src;
   assign bus.out_illegal_count = cnt_p1;

endmodule
